// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin merge of two writeback ports into one register-file write port.
// Registers the winning request for one cycle and flags read indices that match the write in flight.
module regfile_write_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int PROTECT_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              Fwd1,
  output logic              Fwd2,
  output logic [7:0]        DropCount
);
  logic              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        drop_q, drop_d;
  logic              xfer, drop;
  logic [ADDR_W-1:0] sel_reg;
  // ptr_q=0 prefers A; after a grant it prefers the port that just lost
  assign a_ready = rst_n && a_valid && (!b_valid || !ptr_q);
  assign b_ready = rst_n && b_valid && (!a_valid || ptr_q);
  assign xfer    = a_ready || b_ready;
  assign sel_reg = a_ready ? a_reg : b_reg;
  assign drop    = (PROTECT_R0 != 0) && xfer && (sel_reg == '0);
  always_comb begin
    ptr_d   = a_ready ? 1'b1 : b_ready ? 1'b0 : ptr_q;
    we_d    = xfer && !drop;
    wreg_d  = xfer ? sel_reg : wreg_q;
    wdata_d = a_ready ? a_data : b_ready ? b_data : wdata_q;
    drop_d  = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      drop_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      drop_q  <= drop_d;
    end
  end
  assign RegWrite      = we_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign DropCount     = drop_q;
  assign Fwd1          = we_q && (wreg_q == ReadRegister1);
  assign Fwd2          = we_q && (wreg_q == ReadRegister2);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table for the write arbiter plus hand-written
// sequences for reset mid-flight and DropCount saturation.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [3:0]  a_reg, b_reg, rr1, rr2, wreg;
  logic [15:0] a_data, b_data, wdata;
  logic        rw, fwd1, fwd2;
  logic [7:0]  dc;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .WriteRegister(wreg), .WriteData(wdata), .RegWrite(rw),
    .ReadRegister1(rr1), .ReadRegister2(rr2), .Fwd1(fwd1), .Fwd2(fwd2),
    .DropCount(dc)
  );

  typedef struct {
    logic        av; logic [3:0] ar; logic [15:0] ad;
    logic        bv; logic [3:0] br; logic [15:0] bd;
    logic [3:0]  r1, r2;
    logic        ea, eb, erw, cw;
    logic [3:0]  ewr; logic [15:0] ewd;
    logic        ef1, ef2;
    logic [7:0]  edc;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [3:0] br, input logic [15:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  initial begin
    //       av ar ad       bv br bd       r1  r2  ea eb erw cw ewr ewd      f1 f2 dc
    vt[0]  = '{1, 2, 16'h5,    1, 3, 16'h7,    15, 15, 1, 0, 1, 1, 2, 16'h5,    0, 0, 0};
    vt[1]  = '{1, 2, 16'h5,    1, 3, 16'h7,    15, 15, 0, 1, 1, 1, 3, 16'h7,    0, 0, 0};
    vt[2]  = '{1, 2, 16'h5,    1, 3, 16'h7,    15, 15, 1, 0, 1, 1, 2, 16'h5,    0, 0, 0};
    vt[3]  = '{1, 2, 16'h5,    1, 3, 16'h7,    15, 15, 0, 1, 1, 1, 3, 16'h7,    0, 0, 0};
    vt[4]  = '{0, 0, 16'h0,    0, 0, 16'h0,    15, 15, 0, 0, 0, 1, 3, 16'h7,    0, 0, 0};
    vt[5]  = '{1, 1, 16'd15,   0, 0, 16'h0,    15, 15, 1, 0, 1, 1, 1, 16'd15,   0, 0, 0};
    vt[6]  = '{0, 0, 16'h0,    0, 0, 16'h0,    15, 15, 0, 0, 0, 1, 1, 16'd15,   0, 0, 0};
    vt[7]  = '{0, 0, 16'h0,    1, 6, 16'h9,    15, 15, 0, 1, 1, 1, 6, 16'h9,    0, 0, 0};
    vt[8]  = '{1, 5, 16'h1111, 1, 5, 16'h2222, 15, 15, 1, 0, 1, 1, 5, 16'h1111, 0, 0, 0};
    vt[9]  = '{1, 5, 16'h1111, 1, 5, 16'h2222, 15, 15, 0, 1, 1, 1, 5, 16'h2222, 0, 0, 0};
    vt[10] = '{1, 4, 16'h44,   0, 0, 16'h0,    4,  2,  1, 0, 1, 1, 4, 16'h44,   1, 0, 0};
    vt[11] = '{0, 0, 16'h0,    0, 0, 16'h0,    4,  2,  0, 0, 0, 1, 4, 16'h44,   0, 0, 0};
    vt[12] = '{1, 0, 16'h1,    0, 0, 16'h0,    15, 15, 1, 0, 0, 0, 0, 16'h0,    0, 0, 1};
    vt[13] = '{1, 0, 16'h2,    0, 0, 16'h0,    15, 15, 1, 0, 0, 0, 0, 16'h0,    0, 0, 2};
    vt[14] = '{1, 0, 16'h3,    0, 0, 16'h0,    15, 15, 1, 0, 0, 0, 0, 16'h0,    0, 0, 3};
    vt[15] = '{0, 0, 16'h0,    0, 0, 16'h0,    15, 15, 0, 0, 0, 0, 0, 16'h0,    0, 0, 3};

    rst_n = 1'b0;
    rr1 = 4'd15; rr2 = 4'd15;
    drive(1, 1, 16'h1, 1, 2, 16'h2);
    #3;
    check("rst_a_ready", -1, a_ready, 0);
    check("rst_b_ready", -1, b_ready, 0);
    check("rst_regwrite", -1, rw, 0);
    check("rst_wreg", -1, wreg, 0);
    check("rst_wdata", -1, wdata, 0);
    check("rst_dropcount", -1, dc, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].bv, vt[i].br, vt[i].bd);
      rr1 = vt[i].r1; rr2 = vt[i].r2;
      #1;
      check("a_ready", i, a_ready, vt[i].ea);
      check("b_ready", i, b_ready, vt[i].eb);
      @(posedge clk);
      #1;
      check("RegWrite", i, rw, vt[i].erw);
      if (vt[i].cw) begin
        check("WriteRegister", i, wreg, vt[i].ewr);
        check("WriteData", i, wdata, vt[i].ewd);
      end
      check("Fwd1", i, fwd1, vt[i].ef1);
      check("Fwd2", i, fwd2, vt[i].ef2);
      check("DropCount", i, dc, vt[i].edc);
    end

    // DropCount saturates: 3 drops so far, 257 more would reach 260 without a ceiling
    @(negedge clk);
    drive(1, 0, 16'hdead, 0, 0, 0);
    for (int i = 0; i < 257; i++) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("drop_saturate", 100, dc, 255);
    check("drop_no_write", 100, rw, 0);

    // reset between the transfer edge and the next edge abandons the registered write
    @(negedge clk);
    drive(1, 7, 16'h77, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_rst_regwrite", 200, rw, 1);
    check("pre_rst_wreg", 200, wreg, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", 201, rw, 0);
    check("mid_rst_wreg", 201, wreg, 0);
    check("mid_rst_wdata", 201, wdata, 0);
    check("mid_rst_dropcount", 201, dc, 0);
    check("mid_rst_a_ready", 201, a_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_regwrite", 202, rw, 0);
    @(posedge clk);
    #1;
    check("post_rst_regwrite2", 203, rw, 0);
    // A had just won before reset, so only a reset pointer would favour A here
    @(negedge clk);
    drive(1, 8, 16'h88, 1, 9, 16'h99);
    #1;
    check("post_rst_ptr_a", 204, a_ready, 1);
    check("post_rst_ptr_b", 204, b_ready, 0);
    @(posedge clk);
    #1;
    check("post_rst_wreg", 205, wreg, 8);
    check("post_rst_wdata", 205, wdata, 16'h88);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width (16 registers).
REQ-003 SHALL have parameter PROTECT_R0, default 1; when 1, writes to index 0 are accepted but discarded.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports a_valid, b_valid  input  1 each  write request from requester A (ALU writeback) or B (memory/load writeback).
REQ-007 SHALL have ports a_reg, b_reg  input  ADDR_W each  destination register index.
REQ-008 SHALL have ports a_data, b_data  input  DATA_W each  write data.
REQ-009 SHALL have ports a_ready, b_ready  output  1 each  grant; transfer occurs when valid and ready are both 1 at a clock edge.
REQ-010 SHALL have port WriteRegister  output  ADDR_W  register-file write index.
REQ-011 SHALL have port WriteData  output  DATA_W  register-file write data.
REQ-012 SHALL have port RegWrite  output  1  register-file write enable.
REQ-013 SHALL have ports ReadRegister1, ReadRegister2  input  ADDR_W each  register-file read indices, snooped for hazards.
REQ-014 SHALL have ports Fwd1, Fwd2  output  1 each  read index matches the write in flight.
REQ-015 SHALL have port DropCount  output  8  saturating count of discarded index-0 writes.

Function
REQ-016 SHALL grant at most one requester per cycle; a_ready and b_ready SHALL never both be 1.
REQ-017 SHALL derive ready combinationally from the valids and the round-robin pointer: with one valid, grant it; with both valid, grant the pointer's preferred port; with none, both ready 0.
REQ-018 SHALL hold a 1-bit pointer, reset to prefer A, that moves to prefer the other port after each transfer and holds when there is no transfer.
REQ-019 SHALL register each transferred request into WriteRegister/WriteData, with RegWrite=1 in the following cycle only (one-cycle latency).
REQ-020 SHALL drive RegWrite=0 in any cycle following a no-transfer cycle, with WriteRegister/WriteData holding their previous values.
REQ-021 SHALL, when PROTECT_R0=1 and the transferred index is 0, accept the request, keep RegWrite=0 next cycle, and increment DropCount (saturating at 255).
REQ-022 SHALL drive Fwd1 = RegWrite AND (WriteRegister == ReadRegister1); Fwd2 likewise for ReadRegister2; purely combinational.
REQ-023 SHALL allow back-to-back transfers every cycle; with both valid continuously, grants SHALL alternate A,B,A,B...
REQ-024 SHALL treat same-index requests in the same cycle like any others: winner is written first, loser one cycle later, so the loser's data ends up in the register.
REQ-025 SHALL make no assumption about a requester holding its request while not granted; an unaccepted request is neither latched nor remembered.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force RegWrite=0, WriteRegister=0, WriteData=0, DropCount=0, and the pointer to prefer A.
REQ-027 SHALL hold a_ready=b_ready=0 while rst_n=0.
REQ-028 SHALL, on reset assertion mid-operation, abandon any registered write: no RegWrite pulse follows the first clock edge after rst_n returns to 1 unless a new transfer occurs.

Verification
REQ-029 SHALL cover: A only, a_reg=1, a_data=15 -> a_ready=1; next cycle RegWrite=1, WriteRegister=1, WriteData=15; following cycle RegWrite=0.
REQ-030 SHALL cover: after reset, both valid for 4 cycles (A: reg 2/data 5, B: reg 3/data 7) -> grants A,B,A,B; RegWrite stays 1 with alternating indices 2,3,2,3.
REQ-031 SHALL cover: both valid, a_reg=b_reg=5, a_data=0x1111, b_data=0x2222, held 2 cycles -> writes 0x1111 then 0x2222 to index 5.
REQ-032 SHALL cover: PROTECT_R0=1, A writes index 0 for 3 cycles -> a_ready=1 each cycle, RegWrite never 1, DropCount=3.
REQ-033 SHALL cover: write to index 4 in flight with ReadRegister1=4 and ReadRegister2=2 -> Fwd1=1, Fwd2=0 for that cycle only.
REQ-034 SHALL cover: rst_n pulsed low between the transfer edge and the next edge -> RegWrite=0 immediately and stays 0 with no valids.
